// File: rtl/ifu_fetch_if.sv
// Fetch-unit bundle: redirect input, instruction-memory request/response
// channel and the decode-side output handshake.
interface ifu_fetch_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_misalign;

    modport master (
        input  redirect_valid, redirect_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  out_ready,
        output imem_req_valid, imem_addr,
        output out_valid, out_pc, out_inst, out_misalign
    );

    modport slave (
        output redirect_valid, redirect_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output out_ready,
        input  imem_req_valid, imem_addr,
        input  out_valid, out_pc, out_inst, out_misalign
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues one fetch at a time, presents
// {pc, inst} to decode, squashes in-flight fetches on redirect.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst,
    ifu_fetch_if.master   bus_io
);

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        drop_q, drop_d;
    logic [31:0] out_inst_q, out_inst_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic        out_mis_q, out_mis_d;

    logic pc_aligned;
    logic req_valid;
    logic out_valid;

    assign pc_aligned = (pc_q[1:0] == 2'b00);
    assign req_valid  = !rst && (state_q == ST_REQ) && !bus_io.redirect_valid && pc_aligned;
    assign out_valid  = !rst && (state_q == ST_OUT) && !bus_io.redirect_valid;

    assign bus_io.imem_req_valid = req_valid;
    assign bus_io.imem_addr      = pc_q;
    assign bus_io.out_valid      = out_valid;
    assign bus_io.out_pc         = out_pc_q;
    assign bus_io.out_inst       = out_inst_q;
    assign bus_io.out_misalign   = out_mis_q;

    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        pc_d       = pc_q;
        drop_d     = drop_q;
        out_inst_d = out_inst_q;
        out_pc_d   = out_pc_q;
        out_mis_d  = out_mis_q;

        if (bus_io.redirect_valid) begin
            pc_d = bus_io.redirect_pc;
            case (state_q)
                ST_REQ:  state_d = ST_REQ;
                ST_WAIT: begin
                    // A response landing with the redirect is the outstanding one: consume it now.
                    if (bus_io.imem_rsp_valid) begin
                        state_d = ST_REQ;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end
                default: state_d = ST_REQ;
            endcase
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (!pc_aligned) begin
                        state_d    = ST_OUT;
                        out_inst_d = NOP_INST;
                        out_pc_d   = pc_q;
                        out_mis_d  = 1'b1;
                    end else if (bus_io.imem_req_ready) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus_io.imem_rsp_valid) begin
                        if (drop_q) begin
                            state_d = ST_REQ;
                            drop_d  = 1'b0;
                        end else begin
                            state_d    = ST_OUT;
                            out_inst_d = bus_io.imem_rsp_data;
                            out_pc_d   = pc_q;
                            out_mis_d  = 1'b0;
                        end
                    end
                end
                ST_OUT: begin
                    if (bus_io.out_ready) begin
                        pc_d    = pc_q + 32'd4;
                        state_d = ST_REQ;
                    end
                end
                default: state_d = ST_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_REQ;
            pc_q       <= RESET_PC;
            drop_q     <= 1'b0;
            out_inst_q <= 32'd0;
            out_pc_q   <= 32'd0;
            out_mis_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q    <= state_d;
            pc_q       <= pc_d;
            drop_q     <= drop_d;
            out_inst_q <= out_inst_d;
            out_pc_q   <= out_pc_d;
            out_mis_q  <= out_mis_d;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed per-cycle vector table, hand sequences for
// reset/wrap, then random traffic against a transaction-level PC model.
module tb_ifu_fetch;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    ifu_fetch_if bus ();

    ifu_fetch #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        rqr;
        logic        rsv;
        logic [31:0] rsd;
        logic        ordy;
        logic        e_rqv;
        logic [31:0] e_addr;
        logic        e_ov;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        e_mis;
    } vec_t;

    vec_t vecs[30];

    function automatic vec_t mk(input logic rv, input logic [31:0] rpc, input logic rqr,
                                input logic rsv, input logic [31:0] rsd, input logic ordy,
                                input logic e_rqv, input logic [31:0] e_addr, input logic e_ov,
                                input logic [31:0] e_pc, input logic [31:0] e_inst, input logic e_mis);
        vec_t v;
        v.rv = rv; v.rpc = rpc; v.rqr = rqr; v.rsv = rsv; v.rsd = rsd; v.ordy = ordy;
        v.e_rqv = e_rqv; v.e_addr = e_addr; v.e_ov = e_ov;
        v.e_pc = e_pc; v.e_inst = e_inst; v.e_mis = e_mis;
        return v;
    endfunction

    // Memory contents used by the random phase: any address-dependent pattern will do.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return ~a ^ {a[15:0], a[31:16]} ^ 32'h0F0F_3C3C;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rv, input logic [31:0] rpc, input logic rqr,
                         input logic rsv, input logic [31:0] rsd, input logic ordy);
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.imem_req_ready = rqr;
        bus.imem_rsp_valid = rsv;
        bus.imem_rsp_data  = rsd;
        bus.out_ready      = ordy;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Random-phase model state
    logic [31:0] m_pc;
    bit          pending;
    int          cd;
    logic [31:0] paddr;
    bit          hold;
    logic [31:0] h_pc, h_inst;
    logic        h_mis;
    int          idle;
    int          accepts;

    initial begin
        vecs[0]  = mk(0, 0,            1, 0, 0,            1, 1, 32'h8000_0000, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0,            0, 1, 32'h0010_0093, 1, 0, 32'h8000_0000, 0, 0, 0, 0);
        vecs[2]  = mk(0, 0,            0, 0, 0,            1, 0, 32'h8000_0000, 1, 32'h8000_0000, 32'h0010_0093, 0);
        vecs[3]  = mk(0, 0,            1, 0, 0,            1, 1, 32'h8000_0004, 0, 0, 0, 0);
        vecs[4]  = mk(0, 0,            0, 1, 32'h0050_0093, 0, 0, 32'h8000_0004, 0, 0, 0, 0);
        for (int i = 5; i < 10; i++)
            vecs[i] = mk(0, 0,         1, 0, 0,            0, 0, 32'h8000_0004, 1, 32'h8000_0004, 32'h0050_0093, 0);
        vecs[10] = mk(0, 0,            1, 0, 0,            1, 0, 32'h8000_0004, 1, 32'h8000_0004, 32'h0050_0093, 0);
        vecs[11] = mk(0, 0,            0, 0, 0,            1, 1, 32'h8000_0008, 0, 0, 0, 0);
        vecs[12] = mk(0, 0,            1, 0, 0,            1, 1, 32'h8000_0008, 0, 0, 0, 0);
        vecs[13] = mk(1, 32'h8000_0100, 1, 0, 0,           1, 0, 32'h8000_0008, 0, 0, 0, 0);
        vecs[14] = mk(0, 0,            1, 0, 0,            1, 0, 32'h8000_0100, 0, 0, 0, 0);
        vecs[15] = mk(0, 0,            1, 0, 0,            1, 0, 32'h8000_0100, 0, 0, 0, 0);
        vecs[16] = mk(0, 0,            1, 1, 32'hDEAD_BEEF, 1, 0, 32'h8000_0100, 0, 0, 0, 0);
        vecs[17] = mk(0, 0,            1, 0, 0,            1, 1, 32'h8000_0100, 0, 0, 0, 0);
        vecs[18] = mk(1, 32'h8000_0200, 1, 1, 32'h1111_1111, 1, 0, 32'h8000_0100, 0, 0, 0, 0);
        vecs[19] = mk(0, 0,            1, 0, 0,            1, 1, 32'h8000_0200, 0, 0, 0, 0);
        vecs[20] = mk(0, 0,            0, 1, 32'h2222_2222, 0, 0, 32'h8000_0200, 0, 0, 0, 0);
        vecs[21] = mk(1, 32'h8000_0102, 1, 0, 0,           1, 0, 32'h8000_0200, 0, 0, 0, 0);
        vecs[22] = mk(0, 0,            1, 0, 0,            0, 0, 32'h8000_0102, 0, 0, 0, 0);
        vecs[23] = mk(0, 0,            1, 0, 0,            1, 0, 32'h8000_0102, 1, 32'h8000_0102, NOP_INST, 1);
        vecs[24] = mk(0, 0,            1, 0, 0,            0, 0, 32'h8000_0106, 0, 0, 0, 0);
        vecs[25] = mk(0, 0,            1, 0, 0,            1, 0, 32'h8000_0106, 1, 32'h8000_0106, NOP_INST, 1);
        vecs[26] = mk(1, 32'h8000_0300, 1, 0, 0,           1, 0, 32'h8000_010A, 0, 0, 0, 0);
        vecs[27] = mk(0, 0,            1, 0, 0,            1, 1, 32'h8000_0300, 0, 0, 0, 0);
        vecs[28] = mk(0, 0,            0, 1, 32'h3333_3333, 0, 0, 32'h8000_0300, 0, 0, 0, 0);
        vecs[29] = mk(0, 0,            0, 0, 0,            1, 0, 32'h8000_0300, 1, 32'h8000_0300, 32'h3333_3333, 0);

        // Held in reset with ready inputs high: no handshake may appear.
        drive(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_addr", bus.imem_addr, RESET_PC);
        check("rst_out_inst", bus.out_inst, 32'd0);
        check("rst_out_pc", bus.out_pc, 32'd0);
        check("rst_out_mis", 32'(bus.out_misalign), 32'd0);
        @(negedge clk);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            drive(vecs[i].rv, vecs[i].rpc, vecs[i].rqr, vecs[i].rsv, vecs[i].rsd, vecs[i].ordy);
            #1;
            check($sformatf("v%0d_req_valid", i), 32'(bus.imem_req_valid), 32'(vecs[i].e_rqv));
            check($sformatf("v%0d_addr", i), bus.imem_addr, vecs[i].e_addr);
            check($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_ov));
            if (vecs[i].e_ov) begin
                check($sformatf("v%0d_out_pc", i), bus.out_pc, vecs[i].e_pc);
                check($sformatf("v%0d_out_inst", i), bus.out_inst, vecs[i].e_inst);
                check($sformatf("v%0d_out_mis", i), 32'(bus.out_misalign), 32'(vecs[i].e_mis));
            end
        end

        // Memory backpressure, then asynchronous reset while a fetch is outstanding.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
            #1;
            check("bp_req_valid", 32'(bus.imem_req_valid), 32'd1);
            check("bp_addr", bus.imem_addr, 32'h8000_0304);
        end
        @(negedge clk);
        drive(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);
        @(negedge clk);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        #1;
        check("wait_req_valid", 32'(bus.imem_req_valid), 32'd0);
        #1;
        rst = 1'b1;
        #1;
        check("arst_addr", bus.imem_addr, RESET_PC);
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check("post_rst_addr", bus.imem_addr, RESET_PC);

        // PC wrap from the top of the address space.
        @(negedge clk);
        drive(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'd0, 1'b0);
        #1;
        check("wrap_redir_req_valid", 32'(bus.imem_req_valid), 32'd0);
        @(negedge clk);
        drive(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0);
        #1;
        check("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
        check("wrap_req_valid", 32'(bus.imem_req_valid), 32'd1);
        @(negedge clk);
        drive(1'b0, 32'd0, 1'b0, 1'b1, 32'hAAAA_0001, 1'b0);
        @(negedge clk);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        #1;
        check("wrap_out_pc", bus.out_pc, 32'hFFFF_FFFC);
        check("wrap_out_inst", bus.out_inst, 32'hAAAA_0001);
        @(negedge clk);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        #1;
        check("wrap_next_addr", bus.imem_addr, 32'h0000_0000);

        // Random traffic against a PC-level model.
        reset_dut();
        m_pc = RESET_PC; pending = 0; cd = 0; paddr = 0;
        hold = 0; h_pc = 0; h_inst = 0; h_mis = 0; idle = 0; accepts = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic        rv, rqr, rsv, ordy, acc;
            logic [31:0] rpc, rsd, exp_inst;
            @(negedge clk);
            rv  = ($urandom_range(0, 19) == 0);
            rpc = RESET_PC + {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            if ($urandom_range(0, 5) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 9) == 0) rpc = 32'hFFFF_FFF8;
            rqr  = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            rsv  = pending && (cd == 0);
            rsd  = rsv ? mem_fn(paddr) : $urandom;
            drive(rv, rpc, rqr, rsv, rsd, ordy);
            #1;
            check("rnd_addr", bus.imem_addr, m_pc);
            if (rv) begin
                check("rnd_redir_out_valid", 32'(bus.out_valid), 32'd0);
                check("rnd_redir_req_valid", 32'(bus.imem_req_valid), 32'd0);
            end
            if (pending) check("rnd_one_outstanding", 32'(bus.imem_req_valid), 32'd0);
            if (bus.imem_req_valid) check("rnd_req_aligned", 32'(m_pc[1:0]), 32'd0);
            if (hold && !rv) begin
                check("rnd_hold_valid", 32'(bus.out_valid), 32'd1);
                check("rnd_hold_pc", bus.out_pc, h_pc);
                check("rnd_hold_inst", bus.out_inst, h_inst);
                check("rnd_hold_mis", 32'(bus.out_misalign), 32'(h_mis));
            end
            acc = bus.out_valid && ordy;
            if (acc) begin
                exp_inst = (m_pc[1:0] != 2'b00) ? NOP_INST : mem_fn(m_pc);
                check("rnd_out_pc", bus.out_pc, m_pc);
                check("rnd_out_inst", bus.out_inst, exp_inst);
                check("rnd_out_mis", 32'(bus.out_misalign), 32'(m_pc[1:0] != 2'b00));
                accepts++;
            end
            idle = (bus.out_valid || rv) ? 0 : idle + 1;
            check("rnd_progress", 32'(idle > 30), 32'd0);
            if (idle > 30) idle = 0;

            hold   = bus.out_valid && !ordy;
            h_pc   = bus.out_pc;
            h_inst = bus.out_inst;
            h_mis  = bus.out_misalign;
            if (rv) m_pc = rpc;
            else if (acc) m_pc = m_pc + 32'd4;
            if (rsv) pending = 0;
            else if (pending) cd--;
            if (bus.imem_req_valid && rqr) begin
                pending = 1;
                paddr   = bus.imem_addr;
                cd      = $urandom_range(0, 3);
            end
        end
        check("rnd_enough_accepts", 32'(accepts >= 100), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
